// File: rtl/firebird7_in_gate1_ijtag_tdr_initiator.sv
// IJTAG initiator: runs one capture-shift-(update) sequence on a single TDR per request
// and returns the TDR contents that were captured during that sequence.
module firebird7_in_gate1_ijtag_tdr_initiator #(
   parameter int TDR_WIDTH = 4
) (
   input  logic                 ijtag_tck,
   input  logic                 ijtag_reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [TDR_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [TDR_WIDTH-1:0] rsp_rdata,
   output logic                 busy,
   output logic                 ijtag_sel,
   output logic                 ijtag_ce,
   output logic                 ijtag_se,
   output logic                 ijtag_ue,
   output logic                 ijtag_si,
   input  logic                 ijtag_so
);
   localparam int CNT_W = $clog2(TDR_WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TDR_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAPTURE = 3'd1,
      S_SHIFT   = 3'd2,
      S_UPDATE  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               state_q;
   logic [TDR_WIDTH-1:0] wbuf_q;
   logic [TDR_WIDTH-1:0] wbuf_d;
   logic [TDR_WIDTH-1:0] rbuf_q;
   logic [TDR_WIDTH-1:0] rbuf_d;
   logic [TDR_WIDTH-1:0] rsp_rdata_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic                 write_q;
   logic                 req_ready_q;
   logic                 busy_q;
   logic                 rsp_valid_q;
   logic                 sel_q;
   logic                 ce_q;
   logic                 se_q;
   logic                 ue_q;
   logic                 si_q;

   // Shift-step next values; the TDR shifts toward bit 0, so ijtag_so enters at the top.
   always_comb begin
      wbuf_d = wbuf_q >> 1;
      rbuf_d = '0;
      rbuf_d[TDR_WIDTH-1] = ijtag_so;
      for (int i = 0; i < TDR_WIDTH - 1; i++) begin
         rbuf_d[i] = rbuf_q[i+1];
      end
      cnt_d = cnt_q + CNT_W'(1);
   end

   // Sequencer; every output is a flop loaded together with the state it belongs to.
   always_ff @(posedge ijtag_tck) begin
      if (!ijtag_reset) begin
         state_q     <= S_IDLE;
         wbuf_q      <= '0;
         rbuf_q      <= '0;
         rsp_rdata_q <= '0;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         sel_q       <= 1'b0;
         ce_q        <= 1'b0;
         se_q        <= 1'b0;
         ue_q        <= 1'b0;
         si_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready_q) begin
                  wbuf_q      <= req_wdata;
                  write_q     <= req_write;
                  rbuf_q      <= '0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  sel_q       <= 1'b1;
                  ce_q        <= 1'b1;
                  state_q     <= S_CAPTURE;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CAPTURE: begin
               cnt_q   <= '0;
               ce_q    <= 1'b0;
               se_q    <= 1'b1;
               si_q    <= wbuf_q[0];
               state_q <= S_SHIFT;
            end
            S_SHIFT: begin
               wbuf_q <= wbuf_d;
               rbuf_q <= rbuf_d;
               cnt_q  <= cnt_d;
               if (cnt_q == CNT_LAST) begin
                  se_q <= 1'b0;
                  si_q <= 1'b0;
                  if (write_q) begin
                     ue_q    <= 1'b1;
                     state_q <= S_UPDATE;
                  end else begin
                     sel_q       <= 1'b0;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rbuf_d;
                     state_q     <= S_DONE;
                  end
               end else begin
                  si_q <= wbuf_d[0];
               end
            end
            S_UPDATE: begin
               ue_q        <= 1'b0;
               sel_q       <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= rbuf_q;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               rsp_valid_q <= 1'b0;
               sel_q       <= 1'b0;
               ce_q        <= 1'b0;
               se_q        <= 1'b0;
               ue_q        <= 1'b0;
               si_q        <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign ijtag_sel = sel_q;
   assign ijtag_ce  = ce_q;
   assign ijtag_se  = se_q;
   assign ijtag_ue  = ue_q;
   assign ijtag_si  = si_q;
endmodule

// File: tb/tb_firebird7_in_gate1_ijtag_tdr_initiator.sv
// Bench for the IJTAG TDR initiator: a 4-bit and a 1-bit instance, each driving a
// behavioural TDR whose latches update on the falling edge during ue.
module tb_firebird7_in_gate1_ijtag_tdr_initiator;
   logic tck = 1'b0;
   logic ijtag_reset = 1'b0;
   always #5 tck = ~tck;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge tck) cyc <= cyc + 1;

   // 4-bit instance signals
   logic       rq_valid4 = 1'b0, rq_write4 = 1'b0;
   logic [3:0] rq_wdata4 = 4'b0000;
   logic       ready4, rv4, busy4, sel4, ce4, se4, ue4, si4;
   logic [3:0] rdata4;
   logic [3:0] sr4 = 4'b0000, lat4 = 4'b0000;
   logic       so4 = 1'b0;

   // 1-bit instance signals
   logic       rq_valid1 = 1'b0, rq_write1 = 1'b0;
   logic [0:0] rq_wdata1 = 1'b0;
   logic       ready1, rv1, busy1, sel1, ce1, se1, ue1, si1;
   logic [0:0] rdata1;
   logic       sr1 = 1'b0, lat1 = 1'b0, so1 = 1'b0;

   firebird7_in_gate1_ijtag_tdr_initiator #(.TDR_WIDTH(4)) dut4 (
      .ijtag_tck(tck), .ijtag_reset(ijtag_reset), .req_valid(rq_valid4), .req_ready(ready4),
      .req_write(rq_write4), .req_wdata(rq_wdata4), .rsp_valid(rv4), .rsp_rdata(rdata4),
      .busy(busy4), .ijtag_sel(sel4), .ijtag_ce(ce4), .ijtag_se(se4), .ijtag_ue(ue4),
      .ijtag_si(si4), .ijtag_so(so4));

   firebird7_in_gate1_ijtag_tdr_initiator #(.TDR_WIDTH(1)) dut1 (
      .ijtag_tck(tck), .ijtag_reset(ijtag_reset), .req_valid(rq_valid1), .req_ready(ready1),
      .req_write(rq_write1), .req_wdata(rq_wdata1), .rsp_valid(rv1), .rsp_rdata(rdata1),
      .busy(busy1), .ijtag_sel(sel1), .ijtag_ce(ce1), .ijtag_se(se1), .ijtag_ue(ue1),
      .ijtag_si(si1), .ijtag_so(so1));

   // TDR models: capture/shift on rising edge, so retimed and latches loaded on falling edge
   always @(posedge tck) begin
      if (sel4 && ce4) sr4 <= lat4;
      else if (sel4 && se4) sr4 <= {si4, sr4[3:1]};
      if (sel1 && ce1) sr1 <= lat1;
      else if (sel1 && se1) sr1 <= si1;
   end
   always @(negedge tck) begin
      so4 <= sr4[0];
      so1 <= sr1;
      if (sel4 && ue4) lat4 <= sr4;
      if (sel1 && ue1) lat1 <= sr1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Output-encoding monitor on both instances
   initial begin
      logic [2:0] v;
      @(posedge tck);
      forever begin
         @(negedge tck);
         v = {(int'(ce4) + int'(se4) + int'(ue4)) > 1, sel4 != (ce4 | se4 | ue4), si4 & ~se4};
         chk("enc4", {29'd0, v}, 32'd0);
         v = {(int'(ce1) + int'(se1) + int'(ue1)) > 1, sel1 != (ce1 | se1 | ue1), si1 & ~se1};
         chk("enc1", {29'd0, v}, 32'd0);
      end
   end

   // Accept monitor for the 4-bit instance (accept happens at the following rising edge)
   int acc_n4 = 0, acc_cyc4 = 0, acc_gap4 = 0;
   initial begin
      forever begin
         @(negedge tck);
         if (ijtag_reset && rq_valid4 && ready4) begin
            acc_n4++;
            acc_gap4 = cyc - acc_cyc4;
            acc_cyc4 = cyc;
         end
      end
   end

   // Call #1 after the accept edge; counts cycles until rsp_valid (cycle 1 = CAPTURE)
   task automatic wait_rsp(input bit one, output int lat, output logic [3:0] rd,
                           output int seln, output int uen);
      lat = 0; rd = 4'b0000; seln = 0; uen = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge tck);
         seln += one ? int'(sel1) : int'(sel4);
         uen  += one ? int'(ue1) : int'(ue4);
         if (one ? rv1 : rv4) begin
            lat = c;
            rd = one ? {3'b000, rdata1} : rdata4;
            break;
         end
      end
      if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_req(input bit one, input logic wr, input logic [3:0] wd,
                          output int lat, output logic [3:0] rd, output int seln, output int uen);
      @(posedge tck); #1;
      if (one) begin rq_valid1 = 1'b1; rq_write1 = wr; rq_wdata1 = wd[0]; end
      else begin rq_valid4 = 1'b1; rq_write4 = wr; rq_wdata4 = wd; end
      @(negedge tck);
      chk(one ? "idle1_ready_rv" : "idle4_ready_rv",
          {30'd0, one ? ready1 : ready4, one ? rv1 : rv4}, 32'd2);
      @(posedge tck); #1;
      rq_valid1 = 1'b0; rq_valid4 = 1'b0;
      wait_rsp(one, lat, rd, seln, uen);
   endtask

   typedef struct {
      logic       wr;
      logic [3:0] wdata;
      logic [3:0] exp_rdata;
      logic [3:0] exp_lat;
      int         exp_latency;
      int         exp_sel;
   } vec_t;
   vec_t vecs[6];

   initial begin
      int lat, seln, uen, a0;
      logic [3:0] rd;
      vecs[0] = '{1'b1, 4'b1011, 4'b0000, 4'b1011, 7, 6};
      vecs[1] = '{1'b1, 4'b0100, 4'b1011, 4'b0100, 7, 6};
      vecs[2] = '{1'b0, 4'b1111, 4'b0100, 4'b0100, 6, 5};
      vecs[3] = '{1'b1, 4'b1001, 4'b0100, 4'b1001, 7, 6};
      vecs[4] = '{1'b0, 4'b0110, 4'b1001, 4'b1001, 6, 5};
      vecs[5] = '{1'b1, 4'b0100, 4'b1001, 4'b0100, 7, 6};

      // Reset state
      repeat (3) @(posedge tck);
      @(negedge tck);
      chk("rst4_ctrl", {24'd0, ready4, busy4, rv4, sel4, ce4, se4, ue4, si4}, 32'h80);
      chk("rst4_rdata", {28'd0, rdata4}, 32'd0);
      chk("rst1_ctrl", {24'd0, ready1, busy1, rv1, sel1, ce1, se1, ue1, si1}, 32'h80);
      @(posedge tck); #1 ijtag_reset = 1'b1;

      // Table-driven requests on the 4-bit TDR
      for (int i = 0; i < 6; i++) begin
         run_req(1'b0, vecs[i].wr, vecs[i].wdata, lat, rd, seln, uen);
         chk($sformatf("vec%0d_rdata", i), {28'd0, rd}, {28'd0, vecs[i].exp_rdata});
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_latency);
         chk($sformatf("vec%0d_sel_cycles", i), seln, vecs[i].exp_sel);
         chk($sformatf("vec%0d_ue_cycles", i), uen, vecs[i].wr ? 1 : 0);
         chk($sformatf("vec%0d_latches", i), {28'd0, lat4}, {28'd0, vecs[i].exp_lat});
      end

      // Reset during the second SHIFT cycle of a write of 1111
      @(posedge tck); #1;
      rq_valid4 = 1'b1; rq_write4 = 1'b1; rq_wdata4 = 4'b1111;
      @(posedge tck); #1 rq_valid4 = 1'b0;
      @(posedge tck); #1;
      @(posedge tck); #1 ijtag_reset = 1'b0;
      @(negedge tck);
      chk("midrst_in_shift", {31'd0, se4}, 32'd1);
      @(posedge tck); #1 ijtag_reset = 1'b1;
      @(negedge tck);
      chk("midrst_ctrl", {24'd0, ready4, busy4, rv4, sel4, ce4, se4, ue4, si4}, 32'h80);
      chk("midrst_rdata", {28'd0, rdata4}, 32'd0);
      uen = 0;
      repeat (12) begin @(negedge tck); uen += int'(ue4); end
      chk("midrst_no_ue", uen, 0);
      chk("midrst_latches", {28'd0, lat4}, 32'h4);
      run_req(1'b0, 1'b0, 4'b0000, lat, rd, seln, uen);
      chk("midrst_readback", {28'd0, rd}, 32'h4);

      // req_valid held high with wdata changing mid-flight
      @(posedge tck); #1;
      a0 = acc_n4;
      rq_valid4 = 1'b1; rq_write4 = 1'b1; rq_wdata4 = 4'b1010;
      @(posedge tck); #1 rq_wdata4 = 4'b0101;
      wait_rsp(1'b0, lat, rd, seln, uen);
      chk("busy_latency", lat, 7);
      chk("busy_rdata", {28'd0, rd}, 32'h4);
      chk("busy_latches", {28'd0, lat4}, 32'hA);
      #1 chk("busy_one_accept", acc_n4 - a0, 1);
      @(negedge tck);
      chk("busy_ready_after_done", {31'd0, ready4}, 32'd1);
      #1 chk("busy_second_accept", acc_n4 - a0, 2);
      chk("b2b_gap", acc_gap4, 8);
      @(posedge tck); #1 rq_valid4 = 1'b0;
      wait_rsp(1'b0, lat, rd, seln, uen);
      chk("busy2_rdata", {28'd0, rd}, 32'hA);
      chk("busy2_latches", {28'd0, lat4}, 32'h5);
      repeat (4) @(negedge tck);
      #1 chk("busy_no_extra_accept", acc_n4 - a0, 2);

      // 1-bit TDR
      run_req(1'b1, 1'b1, 4'b0001, lat, rd, seln, uen);
      chk("n1_wr_rdata", {28'd0, rd}, 32'd0);
      chk("n1_wr_latency", lat, 4);
      chk("n1_wr_sel_cycles", seln, 3);
      chk("n1_wr_latch", {31'd0, lat1}, 32'd1);
      run_req(1'b1, 1'b0, 4'b0000, lat, rd, seln, uen);
      chk("n1_rd_rdata", {28'd0, rd}, 32'd1);
      chk("n1_rd_latency", lat, 3);
      chk("n1_rd_ue", uen, 0);

      repeat (2) @(posedge tck);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
